// File: rtl/dmem_bank.sv
// Single-ported data memory behind the core's load/store port.
// One request in flight: accept in IDLE, wait latency_p cycles, hold the response until yumi_i.
module dmem_bank #(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_not_word_i,
  input  logic        yumi_i,
  output logic        yumi_o,
  output logic        valid_o,
  output logic [31:0] read_data_o,
  output logic [15:0] txn_count_o
);

  localparam int unsigned depth_lp    = 2 ** addr_width_p;
  localparam bit          zero_lat_lp = (latency_p == 0);
  localparam logic [3:0]  lat_init_lp = zero_lat_lp ? 4'd0 : 4'(latency_p - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [addr_width_p-1:0] idx_q;
  logic [1:0]              lane_q;
  logic [31:0]             wdata_q;
  logic                    wen_q;
  logic                    bnw_q;
  logic                    valid_q;
  logic [31:0]             rdata_q;
  logic [15:0]             txn_count_q;

  logic [31:0] mem_q [depth_lp];

  // Address bits above the array range alias and are dropped here.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:addr_width_p+2];

  assign yumi_o = (state_q == IDLE) && valid_i && !reset;

  // Access operands: live inputs when the access happens on the accept edge, latched ones otherwise.
  logic [addr_width_p-1:0] acc_idx_c;
  logic [1:0]              acc_lane_c;
  logic [31:0]             acc_wdata_c;
  logic                    acc_wen_c;
  logic                    acc_bnw_c;
  logic                    access_c;

  assign acc_idx_c   = (state_q == IDLE) ? addr_i[addr_width_p+1:2] : idx_q;
  assign acc_lane_c  = (state_q == IDLE) ? addr_i[1:0] : lane_q;
  assign acc_wdata_c = (state_q == IDLE) ? write_data_i : wdata_q;
  assign acc_wen_c   = (state_q == IDLE) ? wen_i : wen_q;
  assign acc_bnw_c   = (state_q == IDLE) ? byte_not_word_i : bnw_q;
  assign access_c    = !reset && ((zero_lat_lp && yumi_o) || ((state_q == BUSY) && (cnt_q == 4'd0)));

  logic [31:0] rd_word_c;
  logic [3:0]  be_d;
  logic [31:0] wword_d;
  logic [31:0] load_d;

  always_comb begin
    rd_word_c = mem_q[acc_idx_c];
    be_d      = 4'hF;
    wword_d   = acc_wdata_c;
    load_d    = rd_word_c;
    if (acc_bnw_c) begin
      be_d    = 4'(4'b0001 << acc_lane_c);
      wword_d = {4{acc_wdata_c[7:0]}};
      load_d  = {24'h0, rd_word_c[{acc_lane_c, 3'b000} +: 8]};
    end
    if (acc_wen_c) begin
      load_d = 32'h0;
    end
  end

  // Array is never cleared by reset; a store dropped by reset never reaches here.
  always_ff @(posedge clk) begin
    if (access_c && acc_wen_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) begin
          mem_q[acc_idx_c][8*b +: 8] <= wword_d[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'h0;
      wen_q       <= 1'b0;
      bnw_q       <= 1'b0;
      valid_q     <= 1'b0;
      rdata_q     <= 32'h0;
      txn_count_q <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            idx_q   <= addr_i[addr_width_p+1:2];
            lane_q  <= addr_i[1:0];
            wdata_q <= write_data_i;
            wen_q   <= wen_i;
            bnw_q   <= byte_not_word_i;
            cnt_q   <= lat_init_lp;
            if (zero_lat_lp) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              rdata_q <= load_d;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            rdata_q <= load_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (yumi_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            txn_count_q <= txn_count_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o     = valid_q;
  assign read_data_o = rdata_q;
  assign txn_count_o = txn_count_q;

endmodule
